// File: rtl/bscan_byte_bridge_if.sv
// Byte stream from the JTAG bridge to the puzzle core.
// The bridge drives the head byte and valid flag; the core answers with ready.
interface bscan_byte_bridge_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/bscan_byte_bridge.sv
// Fabric-side endpoint of the USER-instruction JTAG byte protocol: 8-bit DR scans feed a
// byte FIFO toward the core, and a RESULT_WIDTH-bit scan reads the core's answer on tdo.
module bscan_byte_bridge #(
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    tck,
    input  logic                    rst_n,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic [RESULT_WIDTH-1:0] result_i,
    bscan_byte_bridge_if.master     m,
    output logic                    overflow,
    output logic [15:0]             rx_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [RESULT_WIDTH-1:0] shift_q;
    logic [7:0]              rx_q;
    logic [7:0]              bit_cnt_q;

    logic [7:0]              mem_q [FIFO_DEPTH];
    logic [PtrW:0]           wr_ptr_q;
    logic [PtrW:0]           rd_ptr_q;
    logic                    overflow_q;
    logic [15:0]             rx_count_q;

    logic                    tap_active;
    logic                    update_sel;
    logic                    push;
    logic                    pop;
    logic                    empty;
    logic                    full;
    logic                    push_ok;

    // Capture beats shift beats update if the TAP decode ever asserts more than one.
    always_comb begin
        tap_active = ir_is_user && !test_logic_reset;
        update_sel = tap_active && update_dr && !capture_dr && !shift_dr;
        push       = update_sel && (bit_cnt_q == 8'd8);
        pop        = m.m_valid && m.m_ready;
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        // A pop in the same cycle frees the slot a full FIFO is about to reuse.
        push_ok    = push && (!full || pop);
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            shift_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
        end else if (test_logic_reset) begin
            shift_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
        end else if (ir_is_user) begin
            if (capture_dr) begin
                shift_q   <= result_i;
                bit_cnt_q <= '0;
            end else if (shift_dr) begin
                shift_q <= {tdi, shift_q[RESULT_WIDTH-1:1]};
                rx_q    <= {tdi, rx_q[7:1]};
                if (bit_cnt_q != 8'hFF) begin
                    bit_cnt_q <= bit_cnt_q + 8'd1;
                end
            end else if (update_dr) begin
                bit_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rx_count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                rx_count_q <= rx_count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge tck) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= rx_q;
        end
    end

    assign m.m_data  = mem_q[rd_ptr_q[PtrW-1:0]];
    assign m.m_valid = !empty;
    assign tdo       = shift_q[0];
    assign overflow  = overflow_q;
    assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_bscan_byte_bridge.sv
// Scoreboard bench for bscan_byte_bridge: directed JTAG scans push expected bytes into a
// queue; a monitor pops and compares every byte the bridge hands to the core.
module tb_bscan_byte_bridge;

    logic        tck = 1'b0;
    logic        rst_n;
    logic        tdi;
    logic        tdo;
    logic        test_logic_reset;
    logic        ir_is_user;
    logic        capture_dr;
    logic        shift_dr;
    logic        update_dr;
    logic [15:0] result_i;
    logic        overflow;
    logic [15:0] rx_count;

    int          tests = 0;
    int          fails = 0;
    int          pops_seen = 0;
    logic [7:0]  exp_q[$];

    bscan_byte_bridge_if sif ();

    bscan_byte_bridge #(
        .RESULT_WIDTH (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .tck              (tck),
        .rst_n            (rst_n),
        .tdi              (tdi),
        .tdo              (tdo),
        .test_logic_reset (test_logic_reset),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .result_i         (result_i),
        .m                (sif),
        .overflow         (overflow),
        .rx_count         (rx_count)
    );

    always #5 tck = ~tck;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: a byte is consumed at the posedge following a negedge that shows valid&ready.
    always @(negedge tck) begin
        if (rst_n === 1'b1 && sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
            logic [7:0] e;
            tests++;
            pops_seen++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got 0x%02h, expected no byte", sif.m_data);
            end else begin
                e = exp_q.pop_front();
                if (sif.m_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got 0x%02h, expected 0x%02h", sif.m_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Capture, n shift cycles (LSB first), Exit1, Update, back to idle.
    task automatic scan(input logic [7:0] v, input int n, input bit rdy_on_update);
        logic saved_rdy;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        for (int i = 0; i < n; i++) begin
            shift_dr = 1'b1;
            tdi      = (i < 8) ? v[i] : 1'b0;
            step();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        step();
        saved_rdy = sif.m_ready;
        if (rdy_on_update) sif.m_ready = 1'b1;
        update_dr = 1'b1;
        step();
        update_dr   = 1'b0;
        sif.m_ready = saved_rdy;
        step();
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        sif.m_ready = 1'b1;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        step();
        step();
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [15:0] got;
        rst_n            = 1'b0;
        tdi              = 1'b0;
        test_logic_reset = 1'b0;
        ir_is_user       = 1'b1;
        capture_dr       = 1'b0;
        shift_dr         = 1'b0;
        update_dr        = 1'b0;
        result_i         = 16'h0000;
        sif.m_ready      = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check("reset_tdo", {31'd0, tdo}, 32'd0);
        check("reset_m_valid", {31'd0, sif.m_valid}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_rx_count", {16'd0, rx_count}, 32'd0);

        // Single byte with the core always ready.
        sif.m_ready = 1'b1;
        exp_q.push_back(8'h41);
        scan(8'h41, 8, 1'b0);
        drain(20);
        check("single_pops", pops_seen, 1);
        check("single_rx_count", {16'd0, rx_count}, 32'd1);
        check("single_m_valid_idle", {31'd0, sif.m_valid}, 32'd0);

        // Readback scan: capture result, collect tdo LSB first; no byte pushed.
        result_i   = 16'h1234;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        check("capture_tdo", {31'd0, tdo}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            got[i]   = tdo;
            shift_dr = 1'b1;
            tdi      = 1'b0;
            step();
        end
        shift_dr  = 1'b0;
        step();
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        step();
        check("readback_value", {16'd0, got}, 32'h1234);
        check("readback_rx_count", {16'd0, rx_count}, 32'd1);
        check("readback_m_valid", {31'd0, sif.m_valid}, 32'd0);

        // Overflow: core stalled, five bytes into a four-deep FIFO.
        do_reset();
        sif.m_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            scan(8'(b), 8, 1'b0);
        end
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_rx_count", {16'd0, rx_count}, 32'd4);
        check("ovf_m_valid", {31'd0, sif.m_valid}, 32'd1);
        drain(20);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        check("ovf_cleared_by_reset", {31'd0, overflow}, 32'd0);

        // Full FIFO with a simultaneous pop on the update edge: no byte lost.
        sif.m_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            scan(8'(b), 8, 1'b0);
        end
        exp_q.push_back(8'h55);
        scan(8'h55, 8, 1'b1);
        check("full_pushpop_overflow", {31'd0, overflow}, 32'd0);
        check("full_pushpop_rx_count", {16'd0, rx_count}, 32'd5);
        drain(20);

        // Wrong bit counts never push.
        do_reset();
        sif.m_ready = 1'b1;
        pops_seen   = 0;
        scan(8'hFF, 9, 1'b0);
        check("nine_bit_m_valid", {31'd0, sif.m_valid}, 32'd0);
        scan(8'h7F, 7, 1'b0);
        check("seven_bit_m_valid", {31'd0, sif.m_valid}, 32'd0);
        scan(8'h00, 0, 1'b0);
        scan(8'h00, 264, 1'b0); // a wrapping counter would read 8 here
        check("bad_len_rx_count", {16'd0, rx_count}, 32'd0);
        check("bad_len_pops", pops_seen, 0);

        // Non-USER IR: TAP activity ignored.
        ir_is_user = 1'b0;
        scan(8'h3C, 8, 1'b0);
        ir_is_user = 1'b1;
        check("non_user_rx_count", {16'd0, rx_count}, 32'd0);

        // Test-Logic-Reset mid-scan clears the bit count: 5 + 3 bits is no byte.
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        tdi        = 1'b1;
        repeat (5) step();
        shift_dr         = 1'b0;
        test_logic_reset = 1'b1;
        step();
        test_logic_reset = 1'b0;
        shift_dr         = 1'b1;
        repeat (3) step();
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        step();
        check("tlr_rx_count", {16'd0, rx_count}, 32'd0);

        // Reset after bit 4 of a scan, then a clean 0xA5: only 0xA5 arrives.
        pops_seen  = 0;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_dr = 1'b1;
            tdi      = 1'b1;
            step();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        do_reset();
        exp_q.push_back(8'hA5);
        scan(8'hA5, 8, 1'b0);
        drain(20);
        check("abort_pops", pops_seen, 1);
        check("abort_rx_count", {16'd0, rx_count}, 32'd1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
